// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite types for the write-only slave: transfer/response/burst encodings,
// slave FSM states and the debug view exported by the top level.
package ahb3lite_pkg;

   typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} HTRANS_state;
   typedef enum logic {OKAY = 1'b0, ERROR = 1'b1} HRESP_state;
   typedef enum logic [2:0] {SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16} HBURST_Type;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} slave_state;

   localparam logic [2:0] HSIZE_BYTE     = 3'b000;
   localparam logic [2:0] HSIZE_HALFWORD = 3'b001;
   localparam logic [2:0] HSIZE_WORD     = 3'b010;

   localparam logic [5:0] BEAT_CNT_MAX = 6'd63;
   localparam logic [7:0] ERR_CNT_MAX  = 8'd255;

   typedef struct packed {
      slave_state state;
      HBURST_Type burst;
      logic [3:0] wait_cnt;
      logic       dp_valid;
   } slave_dbg_t;

   function automatic logic is_active(input HTRANS_state t);
      return (t == NONSEQ) || (t == SEQ);
   endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// DEPTH x 32 storage: one synchronous write port, one asynchronous read port.
// A read of the word being written shows the old value until the write edge.
module ahb_slave_ram #(
   parameter int DEPTH = 64,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [31:0]      wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [31:0]      rd_data
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/ahb3lite_write_slave_mem.sv
// AHB-Lite write-only slave with programmable wait states and a two-cycle ERROR response.
// Address-phase register, response FSM and beat/error statistics live here; storage is ahb_slave_ram.
module ahb3lite_write_slave_mem
   import ahb3lite_pkg::*;
#(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int          IDX_W     = $clog2(DEPTH)
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic [31:0]      HADDR,
   input  logic [31:0]      HWDATA,
   input  logic             HWRITE,
   input  HBURST_Type       HBURST,
   input  logic [2:0]       HSIZE,
   input  HTRANS_state      HTRANS,
   output logic             HREADY,
   output HRESP_state       HRESP,
   input  logic [3:0]       i_wait_cycles,
   input  logic [IDX_W-1:0] i_rd_idx,
   output logic [31:0]      o_rd_data,
   output logic [5:0]       o_beat_cnt,
   output logic [31:0]      o_last_addr,
   output logic [7:0]       o_err_cnt,
   output slave_dbg_t       o_dbg
);

   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   // Valid/ready: a beat is handed over when HREADY=1 and HTRANS is NONSEQ/SEQ; its data phase
   // occupies the following cycles and completes (HWDATA sampled) on the next cycle with HREADY=1.
   slave_state       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             hready_q, hready_d;
   HRESP_state       hresp_q, hresp_d;
   logic             dp_ok_q, dp_ok_d;
   logic             dp_nonseq_q, dp_nonseq_d;
   logic [31:0]      ap_addr_q, ap_addr_d;
   logic [IDX_W-1:0] ap_idx_q, ap_idx_d;
   HBURST_Type       burst_q, burst_d;
   logic [5:0]       beat_cnt_q, beat_cnt_d;
   logic [31:0]      last_addr_q, last_addr_d;
   logic [7:0]       err_cnt_q, err_cnt_d;

   logic        accept;
   logic        legal;
   logic        wr_en;
   logic [31:0] haddr_off;

   assign haddr_off = HADDR - BASE_ADDR;
   assign accept    = hready_q && is_active(HTRANS);
   assign legal     = HWRITE && (HSIZE == HSIZE_WORD) && (HADDR >= BASE_ADDR) && (haddr_off < DEPTH_W);
   assign wr_en     = hready_q && dp_ok_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hready_d    = hready_q;
      hresp_d     = hresp_q;
      dp_ok_d     = dp_ok_q;
      dp_nonseq_d = dp_nonseq_q;
      ap_addr_d   = ap_addr_q;
      ap_idx_d    = ap_idx_q;
      burst_d     = burst_q;
      beat_cnt_d  = beat_cnt_q;
      last_addr_d = last_addr_q;
      err_cnt_d   = err_cnt_q;

      if (wr_en) begin
         if (dp_nonseq_q) begin
            beat_cnt_d = 6'd1;
         end else if (beat_cnt_q != BEAT_CNT_MAX) begin
            beat_cnt_d = beat_cnt_q + 6'd1;
         end
         last_addr_d = ap_addr_q;
      end

      // Outputs are registered, so the response of a beat is decided when its address is accepted.
      if (hready_q) begin
         if (accept) begin
            ap_addr_d   = HADDR;
            ap_idx_d    = haddr_off[IDX_W-1:0];
            burst_d     = HBURST;
            dp_nonseq_d = (HTRANS == NONSEQ);
            if (!legal) begin
               state_d  = S_ERR1;
               hready_d = 1'b0;
               hresp_d  = ERROR;
               dp_ok_d  = 1'b0;
            end else if (i_wait_cycles == 4'd0) begin
               state_d  = S_IDLE;
               hready_d = 1'b1;
               hresp_d  = OKAY;
               dp_ok_d  = 1'b1;
            end else begin
               state_d  = S_WAIT;
               cnt_d    = i_wait_cycles - 4'd1;
               hready_d = 1'b0;
               hresp_d  = OKAY;
               dp_ok_d  = 1'b1;
            end
         end else begin
            state_d  = S_IDLE;
            hready_d = 1'b1;
            hresp_d  = OKAY;
            dp_ok_d  = 1'b0;
         end
      end else begin
         unique case (state_q)
            S_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_d  = S_IDLE;
                  hready_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            S_ERR1: begin
               state_d  = S_ERR2;
               hready_d = 1'b1;
               hresp_d  = ERROR;
               if (err_cnt_q != ERR_CNT_MAX) begin
                  err_cnt_d = err_cnt_q + 8'd1;
               end
            end
            default: begin
               state_d  = S_IDLE;
               hready_d = 1'b1;
               hresp_d  = OKAY;
               dp_ok_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         hready_q    <= 1'b1;
         hresp_q     <= OKAY;
         dp_ok_q     <= 1'b0;
         dp_nonseq_q <= 1'b0;
         ap_addr_q   <= '0;
         ap_idx_q    <= '0;
         burst_q     <= SINGLE;
         beat_cnt_q  <= '0;
         last_addr_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hready_q    <= hready_d;
         hresp_q     <= hresp_d;
         dp_ok_q     <= dp_ok_d;
         dp_nonseq_q <= dp_nonseq_d;
         ap_addr_q   <= ap_addr_d;
         ap_idx_q    <= ap_idx_d;
         burst_q     <= burst_d;
         beat_cnt_q  <= beat_cnt_d;
         last_addr_q <= last_addr_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   ahb_slave_ram #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_ram (
      .clk     (HCLK),
      .we      (wr_en),
      .wr_idx  (ap_idx_q),
      .wr_data (HWDATA),
      .rd_idx  (i_rd_idx),
      .rd_data (o_rd_data)
   );

   assign HREADY         = hready_q;
   assign HRESP          = hresp_q;
   assign o_beat_cnt     = beat_cnt_q;
   assign o_last_addr    = last_addr_q;
   assign o_err_cnt      = err_cnt_q;
   assign o_dbg.state    = state_q;
   assign o_dbg.burst    = burst_q;
   assign o_dbg.wait_cnt = cnt_q;
   assign o_dbg.dp_valid = dp_ok_q;

endmodule
